// File: rtl/gpu_pkg.sv
// Shared definitions for the pixel clip sink: screen geometry defaults, FSM encodings, queued pixel layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_pkg;

  localparam int GPU_DATA_WIDTH = 8;
  localparam int GPU_COLOR_W    = 16;
  localparam int GPU_SCREEN_W   = 240;
  localparam int GPU_SCREEN_H   = 240;
  localparam int GPU_ADDR_W     = 16;
  localparam int GPU_FIFO_DEPTH = 8;

  // One-hot sink states
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } sink_state_t;

  // One visible pixel waiting for the framebuffer writer
  typedef struct packed {
    logic [GPU_DATA_WIDTH-1:0] x;
    logic [GPU_DATA_WIDTH-1:0] y;
    logic [GPU_COLOR_W-1:0]    colour;
  } pix_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO with occupancy count and synchronous clear.
// Latency: a written entry appears at rd_dat the cycle after the write; no bypass.
// Backpressure: writes when full and reads when empty are ignored; the producer paces itself from count.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_wr;
  logic             do_rd;

  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign do_wr  = wr_en && !full && !clr;
  assign do_rd  = rd_en && !empty && !clr;
  assign count  = cnt_q;
  assign rd_dat = mem[rd_ptr];

  // Storage array holds data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/pixel_clip_sink.sv
// Clips generator pixels to the screen, queues visible ones and emits framebuffer address + colour.
// Latency: valid_i in cycle n gives pix_valid_o in cycle n+2 when queue and output register are empty.
// Backpressure: pix_ready_i stalls the output register; clk_en_o throttles the generator before the queue fills.
// Build option: define PIXEL_CLIP_SINK_STATS_EN to build the saturating clip/pixel counters.
module pixel_clip_sink
  import gpu_pkg::*;
#(
  parameter int DATA_WIDTH = GPU_DATA_WIDTH,
  parameter int COLOR_W    = GPU_COLOR_W,
  parameter int SCREEN_W   = GPU_SCREEN_W,
  parameter int SCREEN_H   = GPU_SCREEN_H,
  parameter int ADDR_W     = GPU_ADDR_W,
  parameter int DEPTH      = GPU_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush_i,
  input  logic [COLOR_W-1:0]    color_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  logic                  done_i,
  output logic                  clk_en_o,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic [ADDR_W-1:0]     pix_addr_o,
  output logic [COLOR_W-1:0]    pix_color_o,
  output logic                  done_o,
  output logic [15:0]           clip_cnt_o,
  output logic [15:0]           pix_cnt_o
);

  localparam int CW       = $clog2(DEPTH) + 1;
  localparam int EN_LIM_I = DEPTH - 1;
  localparam logic [CW:0]         EN_LIM = EN_LIM_I[CW:0];
  localparam logic [DATA_WIDTH:0] X_LIM  = SCREEN_W[DATA_WIDTH:0];
  localparam logic [DATA_WIDTH:0] Y_LIM  = SCREEN_H[DATA_WIDTH:0];

  sink_state_t       state_q;
  sink_state_t       state_d;
  logic [COLOR_W-1:0] color_q;
  logic              live_q;
  logic              clk_en_q;
  logic              visible;
  logic              wr_req;
  logic              wr_en;
  logic              start;
  logic              load;
  logic              drained;
  logic              full;
  logic              fifo_empty;
  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  pix_entry_t        wr_ent;
  pix_entry_t        head;
  logic [$bits(pix_entry_t)-1:0] head_raw;
  logic [ADDR_W-1:0] hx;
  logic [ADDR_W-1:0] hy;
  logic [ADDR_W-1:0] head_addr;

  // Off-screen test also catches coordinates that wrapped past 255 (e.g. x0-r)
  assign visible = ({1'b0, x_i} < X_LIM) && ({1'b0, y_i} < Y_LIM);
  assign wr_req  = valid_i && visible && !flush_i;
  assign wr_en   = wr_req && !full;
  // First pixel of a new primitive: colour is latched here and stats restart
  assign start   = (state_q == ST_IDLE) && valid_i && !flush_i;
  assign load    = !fifo_empty && (!pix_valid_o || pix_ready_i) && !flush_i;
  // Everything will be gone after this edge: queue empty, no write pending, output reg emptying
  assign drained = (count == '0) && !wr_en && (!pix_valid_o || pix_ready_i);

  // The first pixel's colour comes straight from color_i since color_q is not yet loaded
  always_comb begin
    wr_ent        = '0;
    wr_ent.x      = x_i;
    wr_ent.y      = y_i;
    wr_ent.colour = (state_q == ST_IDLE) ? color_i : color_q;
  end

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(pix_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (flush_i),
    .wr_en   (wr_en),
    .wr_dat  (wr_ent),
    .rd_en   (load),
    .rd_dat  (head_raw),
    .count   (count),
    .full    (full),
    .empty   (fifo_empty)
  );

  assign head = pix_entry_t'(head_raw);
  assign hx   = ADDR_W'(head.x);
  assign hy   = ADDR_W'(head.y);

  // 240 columns is y*256 - y*16, so the common case needs no multiplier
  if (SCREEN_W == 240) begin : g_addr_240
    assign head_addr = (hy << 8) - (hy << 4) + hx;
  end else begin : g_addr_mul
    localparam logic [ADDR_W-1:0] SW_A = SCREEN_W[ADDR_W-1:0];
    assign head_addr = hy * SW_A + hx;
  end

  // Output register refills from the queue head whenever empty or being accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_o <= 1'b0;
      pix_addr_o  <= '0;
      pix_color_o <= '0;
    end else if (flush_i) begin
      pix_valid_o <= 1'b0;
    end else if (load) begin
      pix_valid_o <= 1'b1;
      pix_addr_o  <= head_addr;
      pix_color_o <= head.colour;
    end else if (pix_ready_i) begin
      pix_valid_o <= 1'b0;
    end
  end

  // Primitive colour, in-flight pacing flag, and a one-cycle hold-off after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      color_q  <= '0;
      clk_en_q <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      live_q   <= 1'b1;
      clk_en_q <= clk_en_o;
      if (start) begin
        color_q <= color_i;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a pixel coinciding with done_i is written before draining starts
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (done_i) state_d = ST_DRAIN;
                  else if (valid_i) state_d = ST_RUN;
        ST_RUN:   if (done_i) state_d = ST_DRAIN;
        ST_DRAIN: if (drained) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; pacing counts the pixel possibly in flight but ignores pops, so it is conservative
  always_comb begin
    occ      = {1'b0, count} + {{CW{1'b0}}, clk_en_q};
    done_o   = (state_q == ST_DONE);
    clk_en_o = live_q && (state_q != ST_DONE) && !flush_i && (occ <= EN_LIM);
  end

`ifndef SYNTHESIS
  // A pixel arriving with no free slot means the generator ignored clk_en_o
  always_ff @(posedge clk) begin
    if (reset_n && wr_req && full) begin
      $error("pixel_clip_sink: pixel dropped on full queue");
    end
  end
`endif

`ifdef PIXEL_CLIP_SINK_STATS_EN
  logic        drop;
  logic [15:0] clip_q;
  logic [15:0] pix_q;

  assign drop = valid_i && !visible && !flush_i;

  // Saturating per-primitive counters, restarted by the first pixel of a primitive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_q <= '0;
      pix_q  <= '0;
    end else if (flush_i) begin
      clip_q <= '0;
      pix_q  <= '0;
    end else if (start) begin
      clip_q <= {15'd0, drop};
      pix_q  <= {15'd0, wr_en};
    end else begin
      if (drop && (clip_q != 16'hFFFF)) clip_q <= clip_q + 16'd1;
      if (wr_en && (pix_q != 16'hFFFF)) pix_q  <= pix_q + 16'd1;
    end
  end

  assign clip_cnt_o = clip_q;
  assign pix_cnt_o  = pix_q;
`else
  assign clip_cnt_o = '0;
  assign pix_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pixel_clip_sink.sv
// Self-checking bench for pixel_clip_sink: scoreboard of expected pixels plus per-scenario tasks.
// Latency: n/a.
// Backpressure: n/a.
module tb_pixel_clip_sink;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic        valid_i;
  logic        done_i;
  logic        pix_ready_i;
  logic [15:0] color_i;
  logic [7:0]  x_i;
  logic [7:0]  y_i;
  logic        clk_en_o;
  logic        pix_valid_o;
  logic        done_o;
  logic [15:0] pix_addr_o;
  logic [15:0] pix_color_o;
  logic [15:0] clip_cnt_o;
  logic [15:0] pix_cnt_o;

  int  errors = 0;
  int  checks = 0;
  int  n_out  = 0;
  int  n_done = 0;
  time last_hs = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] color;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  exp_t exp_head;

`ifdef PIXEL_CLIP_SINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  pixel_clip_sink dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .color_i     (color_i),
    .valid_i     (valid_i),
    .x_i         (x_i),
    .y_i         (y_i),
    .done_i      (done_i),
    .clk_en_o    (clk_en_o),
    .pix_valid_o (pix_valid_o),
    .pix_ready_i (pix_ready_i),
    .pix_addr_o  (pix_addr_o),
    .pix_color_o (pix_color_o),
    .done_o      (done_o),
    .clip_cnt_o  (clip_cnt_o),
    .pix_cnt_o   (pix_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic bit on_screen(input int x, input int y);
    return (x < 240) && (y < 240);
  endfunction

  function automatic logic [15:0] exp_addr(input int x, input int y);
    return 16'(y * 240 + x);
  endfunction

  // Scoreboard monitor: every accepted pixel must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n && pix_valid_o && pix_ready_i) begin
      n_out++;
      last_hs = $time;
      got = '{addr: pix_addr_o, color: pix_color_o};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got addr=%0d colour=%h with nothing expected", pix_addr_o, pix_color_o);
      end else begin
        exp_head = sb.pop_front();
        if (got !== exp_head) begin
          errors++;
          $display("FAIL pixel_match: got addr=%0d colour=%h, expected addr=%0d colour=%h",
                   got.addr, got.color, exp_head.addr, exp_head.color);
        end
      end
    end
    if (reset_n && done_o) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input logic [15:0] col);
    valid_i = 1'b1;
    x_i     = 8'(x);
    y_i     = 8'(y);
    if (on_screen(x, y)) sb.push_back('{addr: exp_addr(x, y), color: col});
    tick();
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
  endtask

  // Returns the cycle index at which done_o was seen, or -1 if the budget ran out
  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        cyc = i;
        break;
      end
      tick();
    end
    if (cyc >= 0) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; done_i = 1'b0;
    pix_ready_i = 1'b0; color_i = '0; x_i = '0; y_i = '0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({clk_en_o, pix_valid_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: clk_en/valid/done=%b, expected 000", {clk_en_o, pix_valid_o, done_o});
    end
    checks++;
    if ({pix_addr_o, pix_color_o, clip_cnt_o, pix_cnt_o} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h colour=%h clip=%h pix=%h, expected all 0",
               pix_addr_o, pix_color_o, clip_cnt_o, pix_cnt_o);
    end
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (clk_en_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_clk_en: got %b, expected 1", clk_en_o);
    end
    tick();
  endtask

  task automatic test_basic();
    int  xs[3];
    int  ys[3];
    int  base;
    int  cyc;
    int  base_done;
    bit  exp_v;
    xs = '{10, 239, 0};
    ys = '{20, 239, 0};
    base = n_out;
    base_done = n_done;
    pix_ready_i = 1'b1;
    color_i = 16'hF800;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        valid_i = 1'b1;
        x_i = 8'(xs[c]);
        y_i = 8'(ys[c]);
        sb.push_back('{addr: exp_addr(xs[c], ys[c]), color: 16'hF800});
      end else begin
        valid_i = 1'b0;
      end
      if (c == 1) color_i = 16'h1234;
      @(negedge clk);
      exp_v = (c >= 2) && (c <= 4);
      checks++;
      if (pix_valid_o !== exp_v) begin
        errors++;
        $display("FAIL basic_latency c=%0d: pix_valid_o=%b, expected %b", c, pix_valid_o, exp_v);
      end
      tick();
    end
    checks++;
    if (n_out - base != 3) begin
      errors++;
      $display("FAIL basic_count: %0d pixels out, expected 3", n_out - base);
    end
    checks++;
    if (pix_cnt_o !== (STATS ? 16'd3 : 16'd0) || clip_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL basic_stats: pix=%0d clip=%0d, expected pix=%0d clip=0",
               pix_cnt_o, clip_cnt_o, STATS ? 3 : 0);
    end
    pulse_done();
    wait_done(10, cyc);
    repeat (2) tick();
    checks++;
    if (cyc < 0 || n_done - base_done != 1) begin
      errors++;
      $display("FAIL basic_done: done seen at %0d, pulses=%0d, expected one pulse", cyc, n_done - base_done);
    end
  endtask

  task automatic test_clip();
    int xs[3];
    int ys[3];
    int base;
    int cyc;
    xs = '{250, 5, 255};
    ys = '{5, 240, 255};
    base = n_out;
    pix_ready_i = 1'b1;
    color_i = 16'h001F;
    for (int i = 0; i < 3; i++) send(xs[i], ys[i], 16'h001F);
    valid_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (pix_valid_o !== 1'b0 || n_out != base) begin
      errors++;
      $display("FAIL clip_drop: pix_valid_o=%b outputs=%0d, expected 0 and 0", pix_valid_o, n_out - base);
    end
    checks++;
    if (clip_cnt_o !== (STATS ? 16'd3 : 16'd0) || pix_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL clip_stats: clip=%0d pix=%0d, expected clip=%0d pix=0",
               clip_cnt_o, pix_cnt_o, STATS ? 3 : 0);
    end
    tick();
    pulse_done();
    wait_done(10, cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL clip_done: no done_o within budget, expected a pulse");
    end
  endtask

  task automatic test_empty_done();
    int cyc;
    int base;
    base = n_out;
    pulse_done();
    wait_done(8, cyc);
    checks++;
    if (cyc != 1 || n_out != base) begin
      errors++;
      $display("FAIL empty_done: done at cycle %0d outputs=%0d, expected cycle 1 and 0 outputs", cyc, n_out - base);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int n_gen;
    int cyc;
    bit en_prev;
    base = n_out;
    n_gen = 0;
    en_prev = 1'b0;
    pix_ready_i = 1'b0;
    color_i = 16'h07E0;
    for (int c = 0; c < 30; c++) begin
      if (en_prev) begin
        valid_i = 1'b1;
        x_i = 8'(n_gen);
        y_i = 8'd1;
        sb.push_back('{addr: exp_addr(n_gen, 1), color: 16'h07E0});
        n_gen++;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk);
      en_prev = clk_en_o;
      tick();
    end
    valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (n_gen != 9) begin
      errors++;
      $display("FAIL bp_generated: %0d pixels let through, expected 9", n_gen);
    end
    checks++;
    if (clk_en_o !== 1'b0 || pix_valid_o !== 1'b1 || n_out != base) begin
      errors++;
      $display("FAIL bp_stall: clk_en=%b valid=%b outputs=%0d, expected 0, 1, 0", clk_en_o, pix_valid_o, n_out - base);
    end
    tick();
    pulse_done();
    pix_ready_i = 1'b1;
    wait_done(40, cyc);
    checks++;
    if (cyc < 0 || n_out - base != 9 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: done at %0d outputs=%0d left=%0d, expected done, 9 outputs, 0 left",
               cyc, n_out - base, sb.size());
    end
  endtask

  task automatic test_done_toggle();
    int  base_done;
    time t_done;
    base_done = n_done;
    t_done = 0;
    pix_ready_i = 1'b0;
    color_i = 16'hABCD;
    send(3, 4, 16'hABCD);
    send(5, 6, 16'hABCD);
    valid_i = 1'b0;
    pulse_done();
    for (int c = 0; c < 20; c++) begin
      pix_ready_i = (c % 2 == 0);
      @(negedge clk);
      if (done_o && t_done == 0) t_done = $time;
      tick();
    end
    pix_ready_i = 1'b1;
    checks++;
    if (t_done == 0 || (t_done - last_hs) != 10) begin
      errors++;
      $display("FAIL toggle_done_timing: done at t=%0t last handshake t=%0t, expected one cycle apart", t_done, last_hs);
    end
    checks++;
    if (n_done - base_done != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL toggle_done_pulse: pulses=%0d left=%0d, expected 1 and 0", n_done - base_done, sb.size());
    end
  endtask

  task automatic test_flush();
    int base;
    int base_done;
    int cyc;
    base = n_out;
    base_done = n_done;
    pix_ready_i = 1'b0;
    color_i = 16'h1111;
    for (int i = 0; i < 5; i++) send(i, 10, 16'h1111);
    valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (pix_valid_o !== 1'b0 || done_o !== 1'b0 || clk_en_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: valid=%b done=%b clk_en=%b, expected 0, 0, 1", pix_valid_o, done_o, clk_en_o);
    end
    tick();
    pix_ready_i = 1'b1;
    repeat (4) tick();
    checks++;
    if (n_out != base || n_done != base_done || pix_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL flush_empty: outputs=%0d dones=%0d pix=%0d, expected all 0",
               n_out - base, n_done - base_done, pix_cnt_o);
    end
    color_i = 16'h07E0;
    send(1, 1, 16'h07E0);
    valid_i = 1'b0;
    pulse_done();
    wait_done(10, cyc);
    checks++;
    if (cyc < 0 || n_out - base != 1) begin
      errors++;
      $display("FAIL flush_next_prim: done at %0d outputs=%0d, expected done and 1 output", cyc, n_out - base);
    end
  endtask

  task automatic test_reset_mid_drain();
    int base;
    int cyc;
    pix_ready_i = 1'b0;
    color_i = 16'h5555;
    for (int i = 0; i < 3; i++) send(20 + i, 30, 16'h5555);
    valid_i = 1'b0;
    pulse_done();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({clk_en_o, pix_valid_o, done_o} !== 3'b000 ||
        {pix_addr_o, pix_color_o, clip_cnt_o, pix_cnt_o} !== 64'h0) begin
      errors++;
      $display("FAIL reset_async: clk_en/valid/done=%b addr=%h colour=%h, expected all 0",
               {clk_en_o, pix_valid_o, done_o}, pix_addr_o, pix_color_o);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    pix_ready_i = 1'b1;
    base = n_out;
    color_i = 16'h001F;
    send(100, 2, 16'h001F);
    valid_i = 1'b0;
    pulse_done();
    wait_done(10, cyc);
    checks++;
    if (cyc < 0 || n_out - base != 1) begin
      errors++;
      $display("FAIL reset_next_prim: done at %0d outputs=%0d, expected done and 1 output", cyc, n_out - base);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_empty_done();
    test_backpressure();
    test_done_toggle();
    test_flush();
    test_reset_mid_drain();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d pixels never came out, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
